// File: rtl/busy_table.sv
// -----------------------------------------------------------------------------
// busy_table
//
// Physical-register busy table for the rename/issue path. One busy bit per
// physical register: the map stage sets it on allocation, writeback ports
// clear it when the result is produced, and issue-side read ports query
// operand readiness with a same-cycle bypass of writeback clears. A
// registered count of busy entries and a sticky protocol error flag are kept
// alongside.
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   busy_table_wr_en    map-stage write strobe
//   busy_table_wr_addr  physical register to write
//   busy_table_data_in  1 = mark busy, 0 = mark ready
//   wb_clr_en           per-writeback-port clear strobe
//   wb_clr_addr         per-writeback-port register to mark ready
//   flush               pipeline flush, all entries become ready
//   rd_addr             per-read-port query address
//   rd_busy             per-read-port busy status (combinational)
//   busy_count          registered number of busy entries
//   protocol_err        sticky error flag, cleared only by rst
// -----------------------------------------------------------------------------
module busy_table #(
    parameter int PHY_RF_DEPTH = 128,
    parameter int NUM_WB_PORTS = 2,
    parameter int NUM_RD_PORTS = 4,
    localparam int ADDR_W = $clog2(PHY_RF_DEPTH),
    localparam int CNT_W  = $clog2(PHY_RF_DEPTH + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     busy_table_wr_en,
    input  logic [ADDR_W-1:0]                        busy_table_wr_addr,
    input  logic                                     busy_table_data_in,
    input  logic [NUM_WB_PORTS-1:0]                  wb_clr_en,
    input  logic [NUM_WB_PORTS-1:0][ADDR_W-1:0]      wb_clr_addr,
    input  logic                                     flush,
    input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]      rd_addr,
    output logic [NUM_RD_PORTS-1:0]                  rd_busy,
    output logic [CNT_W-1:0]                         busy_count,
    output logic                                     protocol_err
);

    logic [PHY_RF_DEPTH-1:0] busy_r;
    logic [PHY_RF_DEPTH-1:0] busy_next_s;
    logic [PHY_RF_DEPTH-1:0] clr_hit_s;
    logic [PHY_RF_DEPTH-1:0] rise_s;
    logic [PHY_RF_DEPTH-1:0] fall_s;
    logic [CNT_W-1:0]        busy_count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic                    protocol_err_r;
    logic                    err_next_s;
    logic                    wr_valid_s;
    logic                    err_event_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [PHY_RF_DEPTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < PHY_RF_DEPTH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Decode which entries any writeback port clears this cycle (entry 0 never).
    always_comb begin
        clr_hit_s = {PHY_RF_DEPTH{1'b0}};
        for (int i = 1; i < PHY_RF_DEPTH; i++) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                clr_hit_s[i] = clr_hit_s[i] |
                               (wb_clr_en[k] & (wb_clr_addr[k] == ADDR_W'(i)));
            end
        end
    end

    // Next busy vector: flush, then map write, then writeback clear, then hold.
    always_comb begin
        busy_next_s = busy_r;
        wr_valid_s  = busy_table_wr_en & (busy_table_wr_addr != {ADDR_W{1'b0}});
        for (int i = 1; i < PHY_RF_DEPTH; i++) begin
            if (flush) begin
                busy_next_s[i] = 1'b0;
            end else if (wr_valid_s && (busy_table_wr_addr == ADDR_W'(i))) begin
                busy_next_s[i] = busy_table_data_in;
            end else if (clr_hit_s[i]) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
        busy_next_s[0] = 1'b0;
    end

    // Count update and error detection; errors are ignored in a flush cycle.
    always_comb begin
        rise_s      = ~busy_r & busy_next_s;
        fall_s      = busy_r & ~busy_next_s;
        // Reallocating a register that is still busy, or whose writeback
        // lands in the same cycle, means two producers share one register.
        err_event_s = wr_valid_s & busy_table_data_in &
                      (busy_r[busy_table_wr_addr] | clr_hit_s[busy_table_wr_addr]);
        if (flush) begin
            count_next_s = {CNT_W{1'b0}};
            err_next_s   = protocol_err_r;
        end else begin
            count_next_s = busy_count_r + popcount(rise_s) - popcount(fall_s);
            err_next_s   = protocol_err_r | err_event_s;
        end
    end

    // Read ports: stored state with same-cycle writeback clears bypassed.
    always_comb begin
        rd_busy = {NUM_RD_PORTS{1'b0}};
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_busy[p] = busy_r[rd_addr[p]] & ~clr_hit_s[rd_addr[p]];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r         <= {PHY_RF_DEPTH{1'b0}};
            busy_count_r   <= {CNT_W{1'b0}};
            protocol_err_r <= 1'b0;
        end else begin
            busy_r         <= busy_next_s;
            busy_count_r   <= count_next_s;
            protocol_err_r <= err_next_s;
        end
    end

    assign busy_count   = busy_count_r;
    assign protocol_err = protocol_err_r;

endmodule

// File: doc/busy_table.md
# busy_table

Physical-register busy table for the Qu rename/issue path. It holds one busy bit per physical register. The map stage sets a bit when it allocates a destination register. Writeback ports clear the bit when the result is produced. Issue-side read ports query operand readiness, with a same-cycle bypass of writeback clears so dependants can wake up without a bubble. The block also keeps a registered count of busy entries and flags protocol violations.

## Interface

Parameters:
- PHY_RF_DEPTH, 128, number of physical registers; power of two, at least 4
- NUM_WB_PORTS, 2, number of writeback clear ports
- NUM_RD_PORTS, 4, number of operand readiness read ports

Ports (A = $clog2(PHY_RF_DEPTH), C = $clog2(PHY_RF_DEPTH+1)):
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- busy_table_wr_en  in  1  write strobe from the map stage
- busy_table_wr_addr  in  A  physical register to write
- busy_table_data_in  in  1  value to write: 1 = mark busy, 0 = mark ready
- wb_clr_en  in  NUM_WB_PORTS  per-port clear strobe
- wb_clr_addr  in  NUM_WB_PORTS x A  per-port register to mark ready
- flush  in  1  pipeline flush: all entries become ready
- rd_addr  in  NUM_RD_PORTS x A  per-port query address
- rd_busy  out  NUM_RD_PORTS  per-port busy status (combinational)
- busy_count  out  C  registered number of busy entries
- protocol_err  out  1  sticky error flag

## Operation

- Storage is `busy[PHY_RF_DEPTH-1:0]`. Entry 0 is hardwired to 0:
  - writes to address 0 are ignored;
  - clears of address 0 are ignored;
  - reads of address 0 return 0.
- Next-state priority for entry i, highest first:
  1. rst → 0.
  2. flush → 0.
  3. Map write hitting i → `busy_table_data_in`.
  4. Any wb clear hitting i → 0.
  5. Otherwise hold.
- Map write and wb clear to the same non-zero address in the same cycle:
  - the map write wins;
  - if `busy_table_data_in` = 1, `protocol_err` is set;
  - in that case the register was reallocated before its writeback, which is illegal.
- Map write of 1 to an entry that is already busy: the entry stays busy and `protocol_err` is set. This indicates a double allocation.
- Clear of an entry that is already ready: no effect and no error. Writeback of a squashed uop is legal.
- Several wb ports clearing the same address in one cycle: legal; the entry is cleared once.
- Read path, `rd_busy[p]`:
  - equals `busy[rd_addr[p]]` AND NOT (any `wb_clr_en[k]` with `wb_clr_addr[k]` == `rd_addr[p]`);
  - a same-cycle map write is NOT bypassed;
  - flush is NOT bypassed.
- busy_count:
  - `busy_count_next` = `busy_count` + (map write turns a ready entry busy) − (number of distinct busy entries turned ready this cycle, by map write of 0 or by wb clears);
  - it must always equal the popcount of `busy`;
  - it is 0 after rst or flush.
- protocol_err:
  - stays set until rst;
  - flush does not clear it;
  - errors are not evaluated in a cycle with rst or flush.

## Timing

- Reset values: every `busy` entry = 0, `busy_count` = 0, `protocol_err` = 0, and therefore all `rd_busy` = 0.
- Map write: a write in cycle N is visible on `rd_busy` and `busy_count` in cycle N+1.
- Wb clear:
  - a clear in cycle N is visible on `rd_busy` in cycle N (bypass);
  - it is stored, and visible in `busy_count`, at N+1.
- Flush: asserted in cycle N, all entries and `busy_count` are 0 in N+1. Map writes and clears in cycle N are discarded.
- Rst has the same effect as flush and also clears `protocol_err`. Rst asserted mid-stream discards every same-cycle event.
- `protocol_err` rises in the cycle after the offending event.
- No handshake and no stall: every port is accepted every cycle.

## Test plan

- Reset check: assert rst for 2 cycles, then read addresses 0..127 → `rd_busy` = 0 everywhere, `busy_count` = 0, `protocol_err` = 0.
- Set then read:
  - map writes 1 to address 5 in cycle N; `rd_addr[0]` = 5;
  - expect `rd_busy[0]` = 0 in N and 1 in N+1, `busy_count` = 1 in N+1.
- Clear bypass:
  - with entry 5 busy, `wb_clr_en[0]` = 1 and `wb_clr_addr[0]` = 5 in cycle M;
  - expect `rd_busy[0]` = 0 already in M, and `busy_count` to drop by 1 at M+1;
  - duplicate clear of 5 on both wb ports: `busy_count` drops by exactly 1.
- Collision and error:
  - map writes 1 to 9 while `wb_clr_addr[1]` = 9 in the same cycle → entry 9 busy and `protocol_err` = 1 next cycle;
  - `protocol_err` stays 1 after a flush and returns to 0 only after rst.
- Address 0:
  - a map write of 1 to address 0 leaves `rd_busy` for address 0 at 0 and `busy_count` unchanged;
  - `protocol_err` stays 0.
- Flush and random soak:
  - set 10 entries, then flush together with a same-cycle set of address 20 → all entries ready and `busy_count` = 0 next cycle;
  - then run 10k random cycles of sets, clears and reads, checking `rd_busy` and `busy_count` against a reference model every cycle.
